vram_fetch_arb: RTL and testbench

Round-robin burst arbiter sharing one 32-bit read-only port of `vram_if` (if1/if2/if3 style: 15-bit word address, strobe, ack, 32-bit data) between three display fetch requesters. Each requester posts a start word address and a burst length of 1–4 words. The arbiter grants one requester at a time and streams its burst through the VRAM port. It tolerates stalls caused by the higher-priority CPU interface (if0) and returns data words tagged to the owning requester.

---
 rtl/vram_fetch_arb.sv | 167 ++++++++++++++++
 tb/tb_vram_fetch_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_arb.sv
// rtl/vram_fetch_arb.sv - round-robin burst arbiter for three display fetchers on one vram read port
module vram_fetch_arb (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_strobe,
   input  logic [44:0] req_addr,
   input  logic [5:0]  req_len,
   output logic [2:0]  req_valid,
   output logic [2:0]  req_done,
   output logic [31:0] rddata,
   output logic [14:0] vram_addr,
   output logic        vram_strobe,
   input  logic        vram_ack,
   input  logic [31:0] vram_rddata
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  grant;
   logic [1:0]  grant_nxt;
   logic [1:0]  last_grant;
   logic [1:0]  last_grant_nxt;
   logic [14:0] cur_addr;
   logic [14:0] cur_addr_nxt;
   logic [1:0]  remaining;
   logic [1:0]  remaining_nxt;

   logic [1:0]  order0;
   logic [1:0]  order1;
   logic [1:0]  order2;
   logic        pick_valid;
   logic [1:0]  pick;
   logic [14:0] pick_addr;
   logic [1:0]  pick_len;
   logic [2:0]  grant_oh;
   logic [14:0] cur_addr_inc;

   assign grant_oh     = 3'(3'b001 << grant);
   assign cur_addr_inc = cur_addr + 15'd1;

   // scan order starts just after the most recent winner so nobody starves
   always_comb begin
      order0 = 2'd0;
      order1 = 2'd1;
      order2 = 2'd2;
      case (last_grant)
         2'd0: begin
            order0 = 2'd1;
            order1 = 2'd2;
            order2 = 2'd0;
         end
         2'd1: begin
            order0 = 2'd2;
            order1 = 2'd0;
            order2 = 2'd1;
         end
         default: begin
            order0 = 2'd0;
            order1 = 2'd1;
            order2 = 2'd2;
         end
      endcase
   end

   // first requester with its strobe set, in round-robin order
   always_comb begin
      pick_valid = 1'b0;
      pick       = 2'd0;
      if (req_strobe[order0]) begin
         pick_valid = 1'b1;
         pick       = order0;
      end else if (req_strobe[order1]) begin
         pick_valid = 1'b1;
         pick       = order1;
      end else if (req_strobe[order2]) begin
         pick_valid = 1'b1;
         pick       = order2;
      end
   end

   // address and length of the winning requester
   always_comb begin
      pick_addr = req_addr[14:0];
      pick_len  = req_len[1:0];
      case (pick)
         2'd1: begin
            pick_addr = req_addr[29:15];
            pick_len  = req_len[3:2];
         end
         2'd2: begin
            pick_addr = req_addr[44:30];
            pick_len  = req_len[5:4];
         end
         default: begin
            pick_addr = req_addr[14:0];
            pick_len  = req_len[1:0];
         end
      endcase
   end

   // state and burst registers; a reset abandons any burst in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 2'd0;
         last_grant <= 2'd2;
         cur_addr   <= 15'd0;
         remaining  <= 2'd0;
      end else begin
         state      <= state_nxt;
         grant      <= grant_nxt;
         last_grant <= last_grant_nxt;
         cur_addr   <= cur_addr_nxt;
         remaining  <= remaining_nxt;
      end
   end

   // next state and outputs; the ack-to-address path keeps one word per cycle
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant;
      last_grant_nxt = last_grant;
      cur_addr_nxt   = cur_addr;
      remaining_nxt  = remaining;
      vram_strobe    = 1'b0;
      vram_addr      = cur_addr;
      req_valid      = 3'b000;
      req_done       = 3'b000;
      rddata         = 32'd0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               grant_nxt      = pick;
               last_grant_nxt = pick;
               cur_addr_nxt   = pick_addr;
               remaining_nxt  = pick_len;
               state_nxt      = BURST;
            end
         end
         BURST: begin
            vram_strobe = 1'b1;
            if (vram_ack) begin
               vram_addr    = cur_addr_inc;
               req_valid    = grant_oh;
               rddata       = vram_rddata;
               cur_addr_nxt = cur_addr_inc;
               if (remaining == 2'd0) begin
                  req_done    = grant_oh;
                  vram_strobe = 1'b0;
                  state_nxt   = IDLE;
               end else begin
                  remaining_nxt = remaining - 2'd1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_vram_fetch_arb.sv
// tb/tb_vram_fetch_arb.sv - scoreboard bench for vram_fetch_arb
module tb_vram_fetch_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_strobe;
   logic [44:0] req_addr;
   logic [5:0]  req_len;
   logic [2:0]  req_valid;
   logic [2:0]  req_done;
   logic [31:0] rddata;
   logic [14:0] vram_addr;
   logic        vram_strobe;
   logic        vram_ack = 1'b0;
   logic [31:0] vram_rddata = 32'd0;

   vram_fetch_arb dut (
      .clk         (clk),
      .rst         (rst),
      .req_strobe  (req_strobe),
      .req_addr    (req_addr),
      .req_len     (req_len),
      .req_valid   (req_valid),
      .req_done    (req_done),
      .rddata      (rddata),
      .vram_addr   (vram_addr),
      .vram_strobe (vram_strobe),
      .vram_ack    (vram_ack),
      .vram_rddata (vram_rddata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  oh;
      logic [31:0] data;
      logic        done;
   } exp_t;

   exp_t        exp_q[$];
   logic [14:0] addr_q[$];
   exp_t        mon_e;
   logic [14:0] mon_a;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pend[3];
   logic [2:0] pulse;
   logic [14:0] stall_addr;
   int stall_left;
   int hold_cnt;
   int strobe_cnt = 0;
   int last_done_cyc = 0;
   int prev_done_cyc = 0;
   int have_prev = 0;
   int gap_expect = 0;
   logic stall_now;

   assign req_strobe = {pend[2] != 0, pend[1] != 0, pend[0] != 0} | pulse;

   function automatic logic [31:0] ram_word(input logic [14:0] a);
      return {2'b10, a, ~a};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // vram port model: one-cycle ack latency, optional if0 stall on one address
   always @(posedge clk) begin
      stall_now = vram_strobe && (stall_left > 0) && (vram_addr == stall_addr);
      if (vram_strobe) strobe_cnt++;
      if (vram_strobe && vram_addr == stall_addr) hold_cnt++;
      if (stall_now) stall_left--;
      if (vram_strobe && !stall_now) begin
         checks++;
         if (addr_q.size() == 0) begin
            errors++;
            $display("FAIL vram_addr unexpected accept got %h expected none", vram_addr);
         end else begin
            mon_a = addr_q.pop_front();
            if (vram_addr !== mon_a) begin
               errors++;
               $display("FAIL vram_addr got %h expected %h", vram_addr, mon_a);
            end
         end
      end
      vram_ack    <= vram_strobe && !stall_now;
      vram_rddata <= ram_word(vram_addr);
   end

   // requester model: drop the strobe in the done cycle once its bursts are used up
   always @(negedge clk) begin
      if (!rst) begin
         for (int n = 0; n < 3; n++)
            if (req_done[n] && pend[n] > 0) pend[n]--;
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && (req_valid != 3'b000 || req_done != 3'b000)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp unexpected valid %b done %b data %h", req_valid, req_done, rddata);
         end else begin
            mon_e = exp_q.pop_front();
            if (req_valid !== mon_e.oh || rddata !== mon_e.data ||
                req_done !== (mon_e.done ? mon_e.oh : 3'b000)) begin
               errors++;
               $display("FAIL resp got valid %b done %b data %h expected valid %b done %b data %h",
                        req_valid, req_done, rddata, mon_e.oh,
                        mon_e.done ? mon_e.oh : 3'b000, mon_e.data);
            end
         end
         if (req_done != 3'b000) begin
            checks++;
            if (vram_strobe !== 1'b0) begin
               errors++;
               $display("FAIL strobe_in_done got %b expected 0", vram_strobe);
            end
            if (gap_expect != 0 && have_prev != 0) begin
               checks++;
               if (cyc - prev_done_cyc != gap_expect) begin
                  errors++;
                  $display("FAIL grant_gap got %0d expected %0d", cyc - prev_done_cyc, gap_expect);
               end
            end
            prev_done_cyc = cyc;
            have_prev     = 1;
            last_done_cyc = cyc;
         end
      end
   end

   task automatic set_req(input int n, input logic [14:0] a, input int len);
      req_addr[15*n +: 15] = a;
      req_len[2*n +: 2]    = 2'(len);
   endtask

   task automatic push_burst(input int n, input logic [14:0] a, input int first, input int last);
      exp_t e;
      logic [14:0] ak;
      for (int k = first; k <= last; k++) begin
         ak     = a + 15'(k);
         e.oh   = 3'(1 << n);
         e.data = ram_word(ak);
         e.done = (k == last) && (first == 0 || k != last || 1'b1);
         exp_q.push_back(e);
         addr_q.push_back(ak);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, want);
      end
   endtask

   task automatic drain(input int limit);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || addr_q.size() != 0) && i < limit) begin
         @(posedge clk);
         i++;
      end
      checks++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout got %0d resp %0d addr pending expected 0", exp_q.size(), addr_q.size());
         exp_q.delete();
         addr_q.delete();
      end
      repeat (4) @(posedge clk);
      #1;
      check_val("idle_strobe", 32'(vram_strobe), 32'd0);
   endtask

   int t0;
   int s0;
   int found;
   exp_t e0;

   initial begin
      rst        = 1'b1;
      pend[0]    = 0;
      pend[1]    = 0;
      pend[2]    = 0;
      pulse      = 3'b000;
      req_addr   = 45'd0;
      req_len    = 6'd0;
      stall_addr = 15'h7abc;
      stall_left = 0;
      hold_cnt   = 0;

      repeat (3) @(posedge clk);
      #1;
      check_val("reset_valid", 32'(req_valid), 32'd0);
      check_val("reset_done", 32'(req_done), 32'd0);
      check_val("reset_rddata", rddata, 32'd0);
      check_val("reset_strobe", 32'(vram_strobe), 32'd0);
      check_val("reset_addr", 32'(vram_addr), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single 4-word burst from requester 0
      set_req(0, 15'h0100, 3);
      push_burst(0, 15'h0100, 0, 3);
      t0      = cyc;
      pend[0] = 1;
      drain(60);
      check_val("burst_latency", 32'(last_done_cyc - t0), 32'd5);

      // address wrap with no extra strobe
      set_req(1, 15'h7ffe, 3);
      push_burst(1, 15'h7ffe, 0, 3);
      s0      = strobe_cnt;
      pend[1] = 1;
      drain(60);
      check_val("wrap_strobes", 32'(strobe_cnt - s0), 32'd4);

      // if0 stall on the second word
      set_req(2, 15'h0200, 2);
      stall_addr = 15'h0201;
      stall_left = 3;
      hold_cnt   = 0;
      push_burst(2, 15'h0200, 0, 2);
      s0      = strobe_cnt;
      pend[2] = 1;
      drain(60);
      check_val("stall_hold", 32'(hold_cnt), 32'd4);
      check_val("stall_strobes", 32'(strobe_cnt - s0), 32'd6);
      stall_addr = 15'h7abc;

      // three continuous requesters, single words
      set_req(0, 15'h0010, 0);
      set_req(1, 15'h0020, 0);
      set_req(2, 15'h0030, 0);
      for (int r = 0; r < 2; r++) begin
         push_burst(0, 15'h0010, 0, 0);
         push_burst(1, 15'h0020, 0, 0);
         push_burst(2, 15'h0030, 0, 0);
      end
      have_prev  = 0;
      gap_expect = 3;
      pend[0] = 2;
      pend[1] = 2;
      pend[2] = 2;
      drain(100);
      gap_expect = 0;

      // strobe pulse from requester 0 only while requester 2 bursts
      set_req(2, 15'h0300, 3);
      set_req(0, 15'h0555, 1);
      push_burst(2, 15'h0300, 0, 3);
      pend[2] = 1;
      @(posedge clk);
      @(posedge clk);
      #1;
      pulse = 3'b001;
      @(posedge clk);
      #1;
      pulse = 3'b000;
      drain(60);

      // reset after the first word of a 4-word burst
      set_req(1, 15'h0400, 3);
      set_req(0, 15'h0500, 1);
      e0.oh   = 3'b010;
      e0.data = ram_word(15'h0400);
      e0.done = 1'b0;
      exp_q.push_back(e0);
      addr_q.push_back(15'h0400);
      addr_q.push_back(15'h0401);
      push_burst(0, 15'h0500, 0, 1);
      push_burst(1, 15'h0400, 0, 3);
      pend[1] = 1;
      found   = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         @(negedge clk);
         if (req_valid[1]) found = 1;
      end
      checks++;
      if (found == 0) begin
         errors++;
         $display("FAIL reset_wait got no word expected req_valid[1]");
      end
      pend[0] = 1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_val("rst_mid_valid", 32'(req_valid), 32'd0);
      check_val("rst_mid_done", 32'(req_done), 32'd0);
      check_val("rst_mid_rddata", rddata, 32'd0);
      check_val("rst_mid_strobe", 32'(vram_strobe), 32'd0);
      @(negedge clk);
      check_val("rst_hold_valid", 32'(req_valid | req_done), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
